// File: rtl/unified_mem_arbiter.sv
// Single-ported memory arbiter shared by instruction fetch and data access.
// It runs one transaction at a time, and data accesses take priority over fetches.
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_kill,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t state;
  logic   kill_flag;
  logic   d_elig;
  logic   i_elig;

  // A port whose done pulse is showing this cycle is not eligible again until the next cycle.
  assign d_elig  = d_req & ~d_done;
  assign i_elig  = i_req & ~i_done & ~i_kill;

  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      kill_flag <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (d_elig) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (i_elig) begin
            state    <= BUSY_I;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= i_addr;
          end
        end
        BUSY_I: begin
          // A redirect that arrives on the completion cycle also makes the returned word stale.
          if (mem_ready) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            kill_flag <= 1'b0;
            if (!(kill_flag || i_kill)) begin
              i_done  <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end else if (i_kill) begin
            kill_flag <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            d_done  <= 1'b1;
            if (!mem_we) d_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates a single-ported unified instruction/data memory between the pipeline's instruction-fetch (IF) port and data-access (MEM stage) port. It sits between the pipeline and the memory. It issues one memory transaction at a time and gives data accesses priority over fetches. It returns registered done pulses and read data, and derives the IF and MEM stall signals that freeze the pipeline while a port waits.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request valid; held with i_addr until i_done
- i_addr  in  ADDR_W  fetch address (PC)
- i_kill  in  1  discard outstanding or pending fetch (branch/jump redirect)
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  DATA_W  registered fetched instruction
- i_stall  out  1  i_req & ~i_done
- d_req  in  1  data request valid (MemRead | MemWrite); held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  registered load data
- d_stall  out  1  d_req & ~d_done
- mem_req  out  1  memory transaction active; held until mem_ready
- mem_we  out  1  write enable, stable while mem_req
- mem_addr  out  ADDR_W  registered address, stable while mem_req
- mem_wdata  out  DATA_W  registered write data, stable while mem_req
- mem_ready  in  1  memory completes the current transaction this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ready

## Operation
- States:
  - IDLE: no transaction outstanding.
  - BUSY_I: fetch outstanding.
  - BUSY_D: data access outstanding.
- Grant happens in IDLE only. Eligible requests:
  - Data: d_req is high and d_done is low this cycle.
  - Fetch: i_req is high, i_done is low and i_kill is low this cycle.
- Priority: data over fetch, always. An eligible d_req wins. A fetch is granted only when no data request is eligible.
- On grant, the next state is BUSY_D or BUSY_I. mem_req goes to 1. mem_addr, mem_we and mem_wdata load from the winner's inputs.
  - For a fetch, mem_we = 0 and mem_wdata holds its previous value.
- In BUSY_x with mem_ready = 1, the next state is IDLE and mem_req goes to 0.
  - In BUSY_D: d_done <= 1. On a load, d_rdata <= mem_rdata. On a store, d_rdata is unchanged.
  - In BUSY_I: if the kill flag is clear, i_done <= 1 and i_rdata <= mem_rdata. If the kill flag is set, neither changes, and the flag clears.
- Kill flag:
  - Set by i_kill in BUSY_I.
  - Cleared on completion and on reset.
  - i_kill in IDLE or BUSY_D has no effect beyond blocking that cycle's fetch grant.
- A killed fetch still runs to mem_ready, because memory transactions are never aborted.
- mem_ready outside BUSY_x is ignored.
- Requester inputs are sampled only at grant. Changes to them during BUSY do not affect mem_addr or mem_wdata.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE, mem_req = 0, mem_we = 0
  - mem_addr = 0, mem_wdata = 0
  - i_done = 0, d_done = 0, i_rdata = 0, d_rdata = 0, kill flag = 0
  - i_stall and d_stall follow i_req and d_req.
- Reset mid-transaction abandons the transaction: mem_req drops immediately and no done pulse is issued.
- Latency with request in cycle t (IDLE):
  - mem_req is high from t+1.
  - With mem_ready in cycle t+k (k ≥ 1), done is high in cycle t+k+1, together with the new rdata.
  - Minimum request-to-done latency is 2 cycles.
- Done pulses last exactly one cycle, and the state is IDLE during the done cycle.
  - In that cycle, the other port may be granted.
  - The port that just completed is not eligible that cycle. Its next request is eligible from the following cycle.
- Back-to-back throughput for one port is one access per 3 cycles with k = 1.
- i_done and d_done are never high in the same cycle.
- mem_req is never high for more than one transaction without an intervening IDLE cycle.
- i_stall and d_stall are combinational from req and done. There is no other combinational input-to-output path.

## Test plan
- Reset then single fetch:
  - Stimulus: i_req = 1, i_addr = 0x40 at cycle 0; memory responds with mem_ready in cycle 1 and mem_rdata = 0x00500093.
  - Required: mem_req high in cycle 1 with mem_addr = 0x40 and mem_we = 0; i_done pulses in cycle 2 with i_rdata = 0x00500093; i_stall high in cycles 0–1.
- Simultaneous requests:
  - Stimulus: i_req = 1 (0x44) and d_req = 1, d_we = 1 (0x100, 0xDEADBEEF) in cycle 0; memory ready after 1 cycle.
  - Required: the store is issued first with mem_we = 1; d_done pulses in cycle 2; the fetch of 0x44 is granted in cycle 2, mem_req is high in cycle 3 and i_done pulses in cycle 4.
- Wait states:
  - Stimulus: a load from 0x200 with mem_ready delayed 5 cycles.
  - Required: mem_req, mem_addr and mem_we stay stable for 5 cycles; d_done and d_rdata update exactly one cycle after mem_ready; d_stall stays high throughout.
- Kill during fetch:
  - Stimulus: i_kill pulse in cycle 2 of a 4-cycle fetch.
  - Required: no i_done and i_rdata unchanged; the transaction completes; a new fetch at a new i_addr is granted the cycle after return to IDLE.
- Reset mid-transaction:
  - Stimulus: rst_n driven low while in BUSY_D.
  - Required: mem_req drops to 0 asynchronously; all outputs hold their reset values; no done pulse follows.
- Spurious ready:
  - Stimulus: mem_ready = 1 while IDLE.
  - Required: no done pulse; no change to rdata.
